prog_loader: RTL

Parametrised program loader for the ICCM. It takes a byte stream from the programming UART receiver and packs the bytes little-endian into words of configurable width. Each completed word is written to the instruction memory adapter. While loading, it holds the core-side reset asserted, and it releases that reset on a clean end-of-program marker. It replaces the fixed 32-bit loader, adding configurable width and depth, an overflow error, abort handling and an optional checksum.

---
 rtl/prog_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader
//   Packs a UART byte stream little-endian into DATA_W-bit words and writes
//   each completed word to the ICCM adapter. The core is held in reset while a
//   load is in progress. A clean end-of-program marker releases the core reset.
//   Running past DEPTH words traps in an error state.
//
//   Optional feature macro: PROG_LOADER_CHKSUM_EN
//     When it is defined, one check byte follows the marker. The check byte
//     plus the 8-bit sum of all written bytes must equal 0, otherwise the
//     load ends in the error state.
//
//   Handshake: rx_dv_i is a one-cycle strobe with no backpressure. A byte is
//   taken in every RECV cycle where rx_dv_i=1 and prog_i=1. This includes the
//   cycle in which we_o pulses. we_o is a one-cycle write pulse, and
//   addr_o/wdata_o/wmask_o are valid while it is high.
//
//   Ports
//     clk_i, rst_i       clock, asynchronous active-high reset
//     prog_i             programming enable (level); 0 aborts a load
//     rx_dv_i, rx_byte_i received byte strobe and data
//     we_o, addr_o, wdata_o, wmask_o   ICCM write port
//     prog_rst_no        core reset, active low
//     done_o, err_o      load finished cleanly / load failed
//     word_cnt_o         words written in the current load
module prog_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2048,
  parameter logic [DATA_W-1:0] END_WORD = DATA_W'('h0000_0FFF)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                prog_i,
  input  logic                rx_dv_i,
  input  logic [7:0]          rx_byte_i,
  output logic                we_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wmask_o,
  output logic                prog_rst_no,
  output logic                done_o,
  output logic                err_o,
  output logic [ADDR_W:0]     word_cnt_o
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);

`ifdef PROG_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_DONE, S_ERR} state_t;
`endif

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   asm_q;
  // cnt_q counts accepted writes immediately. word_cnt_q lags it by one
  // cycle, so that addr_o still holds the write address while we_o is high.
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       wmask_q;
  logic                rst_n_q;
  logic                done_q;
  logic                err_q;

  logic [DATA_W-1:0]   full_word;
  logic                start;
  logic                byte_in;
  logic                word_done;
  logic                is_end;
  logic                full;
  logic                do_write;

`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0] sum_q;

  function automatic logic [7:0] byte_sum(input logic [DATA_W-1:0] w);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < NB; k++) s = s + w[8*k +: 8];
    return s;
  endfunction
`endif

  // The incoming byte is merged in front of the register so that the last
  // byte of a word can be judged in the cycle it arrives.
  always_comb begin
    full_word = asm_q;
    full_word[{idx_q, 3'b000} +: 8] = rx_byte_i;
  end

  assign start     = (state_q == S_IDLE) && prog_i;
  assign byte_in   = (state_q == S_RECV) && prog_i && rx_dv_i;
  assign word_done = byte_in && (idx_q == LAST_IDX);
  assign is_end    = (full_word == END_WORD);
  assign full      = (cnt_q == DEPTH_C);
  assign do_write  = word_done && !is_end && !full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (prog_i) state_d = S_RECV;
      S_RECV: begin
        if (!prog_i) begin
          state_d = S_IDLE;
        end else if (word_done) begin
          if (is_end) begin
`ifdef PROG_LOADER_CHKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (full) begin
            state_d = S_ERR;
          end
        end
      end
`ifdef PROG_LOADER_CHKSUM_EN
      S_CHK: begin
        if (!prog_i) state_d = S_IDLE;
        else if (rx_dv_i) state_d = (8'(sum_q + rx_byte_i) == 8'h00) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: if (!prog_i) state_d = S_IDLE;
      S_ERR:  if (!prog_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      asm_q      <= '0;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rst_n_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      if (start) begin
        idx_q <= '0;
        cnt_q <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
        sum_q <= 8'h00;
`endif
      end else begin
        if (byte_in) begin
          asm_q[{idx_q, 3'b000} +: 8] <= rx_byte_i;
          idx_q <= word_done ? '0 : idx_q + 1'b1;
        end
        if (do_write) begin
          cnt_q <= cnt_q + 1'b1;
`ifdef PROG_LOADER_CHKSUM_EN
          sum_q <= sum_q + byte_sum(full_word);
`endif
        end
      end
      word_cnt_q <= start ? '0 : cnt_q;
      we_q       <= do_write;
      wmask_q    <= do_write ? '1 : '0;
      if (do_write) wdata_q <= full_word;
      // The core is released only in IDLE and DONE.
      rst_n_q    <= (state_d == S_IDLE) || (state_d == S_DONE);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
    end
  end

  assign we_o        = we_q;
  assign addr_o      = word_cnt_q[ADDR_W-1:0];
  assign wdata_o     = wdata_q;
  assign wmask_o     = wmask_q;
  assign prog_rst_no = rst_n_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign word_cnt_o  = word_cnt_q;

endmodule
